// File: rtl/sound_pkg.sv
// ----------------------------------------------------------------------------
// sound_pkg : shared types, tone table and duration helper for sound_arbiter
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sound_pkg;

    typedef enum logic [1:0] {
        LOSE = 2'd0,
        WIN  = 2'd1,
        GATE = 2'd2,
        HOP  = 2'd3
    } snd_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } snd_state_t;

    localparam int LOSE_FREQ = 950;
    localparam int WIN_FREQ  = 500;
    localparam int GATE_FREQ = 700;
    localparam int HOP_FREQ  = 300;

    function automatic int dur_of(snd_id_t id, int one_sec);
        int d;
        unique case (id)
            LOSE, WIN: d = one_sec;
            GATE:      d = one_sec / 4;
            default:   d = one_sec / 16;
        endcase
        return d;
    endfunction

    function automatic logic [9:0] freq_of(snd_id_t id);
        logic [9:0] f;
        unique case (id)
            LOSE:    f = 10'(LOSE_FREQ);
            WIN:     f = 10'(WIN_FREQ);
            GATE:    f = 10'(GATE_FREQ);
            default: f = 10'(HOP_FREQ);
        endcase
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sound_timer.sv
// ----------------------------------------------------------------------------
// sound_timer : loadable down-counter, stops at zero, shared by PLAY and GAP
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sound_timer #(
    parameter int CW = 26
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          zero
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/sound_arbiter.sv
// ----------------------------------------------------------------------------
// sound_arbiter : fixed-priority, preemptive sharing of the tone generator
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sound_arbiter
    import sound_pkg::*;
#(
    parameter int ONE_SEC    = 50000000,
    parameter int GAP_CYCLES = ONE_SEC / 100
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] req,
    input  logic       mute,
    input  logic       flush,
    output logic [9:0] sound_freq,
    output logic       enable_sound,
    output logic [1:0] active_id,
    output logic       busy
);

    localparam int CW = $clog2(ONE_SEC);

    snd_state_t r_state;
    snd_id_t    r_active;
    logic [3:0] r_pending;
    logic [9:0] r_freq;
    logic       r_enable;
    logic       r_busy;

    snd_state_t    w_state_nxt;
    snd_id_t       w_id_nxt;
    snd_id_t       w_top;
    logic [3:0]    w_cand;
    logic [3:0]    w_pend_nxt;
    logic [3:0]    w_top_bit;
    logic [3:0]    w_act_bit;
    logic          w_grant;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_zero;

    sound_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .resetN (resetN),
        .load   (w_load),
        .value  (w_load_val),
        .zero   (w_zero)
    );

    // Lowest index among pending and fresh requests wins
    always_comb begin
        w_cand = r_pending | req;
        if (w_cand[0])      w_top = LOSE;
        else if (w_cand[1]) w_top = WIN;
        else if (w_cand[2]) w_top = GATE;
        else                w_top = HOP;
        w_top_bit = 4'b0001 << w_top;
        w_act_bit = 4'b0001 << r_active;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_active;
        w_pend_nxt  = r_pending | req;
        w_grant     = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;

        unique case (r_state)
            IDLE: begin
                w_grant = (w_cand != 4'b0000);
            end
            PLAY: begin
                // A re-request of the playing id never lands in pending
                w_pend_nxt = r_pending | (req & ~w_act_bit);
                if ((w_cand != 4'b0000) && (w_top < r_active)) begin
                    w_grant = 1'b1;
                end else if ((req & w_act_bit) != 4'b0000) begin
                    w_load     = 1'b1;
                    w_load_val = CW'(dur_of(r_active, ONE_SEC) - 1);
                end else if (w_zero) begin
                    w_state_nxt = GAP;
                    w_load      = 1'b1;
                    w_load_val  = CW'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (w_zero) begin
                    if (w_cand != 4'b0000) w_grant = 1'b1;
                    else                   w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_grant) begin
            w_state_nxt = PLAY;
            w_id_nxt    = w_top;
            w_pend_nxt  = w_pend_nxt & ~w_top_bit;
            w_load      = 1'b1;
            w_load_val  = CW'(dur_of(w_top, ONE_SEC) - 1);
        end

        if (flush) begin
            w_state_nxt = IDLE;
            w_id_nxt    = r_active;
            w_pend_nxt  = 4'b0000;
            w_grant     = 1'b0;
            w_load      = 1'b1;
            w_load_val  = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= IDLE;
            r_active  <= LOSE;
            r_pending <= 4'b0000;
            r_freq    <= 10'd0;
            r_enable  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_active  <= w_id_nxt;
            r_pending <= w_pend_nxt;
            if (w_grant) r_freq <= freq_of(w_top);
            r_enable  <= (w_state_nxt == PLAY) && !mute;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    assign sound_freq   = r_freq;
    assign enable_sound = r_enable;
    assign active_id    = r_active;
    assign busy         = r_busy;

endmodule

`default_nettype wire

// File: doc/sound_arbiter.md
# sound_arbiter

Shares the single tone generator between the game's sound requesters: lose, win, gate-pass and frog-hop. Latches one-cycle request pulses, grants by fixed priority with preemption, and holds each tone for its fixed duration followed by a silent gap. Sits between the game FSM / gate logic and the audio tone generator. It drives `sound_freq` and `enable_sound` in place of direct FSM control.

## Interface
Parameters:
- `ONE_SEC`, 50000000, cycles per second; benches use 64.
- `GAP_CYCLES`, `ONE_SEC/100`, silent cycles between consecutive tones; must be ≥1.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `req` in 4: one-cycle request pulses. Bit 0 LOSE, bit 1 WIN, bit 2 GATE, bit 3 HOP. Multiple bits may be set in the same cycle.
- `mute` in 1: silences output only; sequencing is unaffected.
- `flush` in 1: synchronous; drops the current tone and all pending requests.
- `sound_freq` out 10: tone frequency in Hz for the tone generator.
- `enable_sound` out 1: tone generator enable.
- `active_id` out 2: id of the tone currently being played.
- `busy` out 1: high in PLAY or GAP.

## Operation
- Per-id constants:
  - LOSE: 950 Hz, DUR = `ONE_SEC`.
  - WIN: 500 Hz, DUR = `ONE_SEC`.
  - GATE: 700 Hz, DUR = `ONE_SEC/4`.
  - HOP: 300 Hz, DUR = `ONE_SEC/16`.
- Priority: LOSE > WIN > GATE > HOP (lowest index wins).
- `pending[3:0]`:
  - Set by `req` bits.
  - The bit for an id is cleared in the cycle that id is granted. A `req` for the same id in the grant cycle merges into that grant.
- States: IDLE, PLAY, GAP.
  - **IDLE:** if `pending|req` is nonzero, grant the highest-priority id, load the counter with DUR-1, and go to PLAY.
  - **PLAY:** counter decrements each cycle.
    - A `req` or pending bit of strictly higher priority than `active_id` preempts immediately: grant it, reload its DUR-1, stay in PLAY. The preempted tone is dropped, not resumed.
    - A `req` for the active id restarts its counter at DUR-1 and does not set pending.
    - Lower or equal-priority requests for other ids only set pending.
    - When the counter reaches 0 and there is no preemption, load GAP_CYCLES-1 and go to GAP.
  - **GAP:** counter decrements each cycle. At 0:
    - If `pending|req` is nonzero, grant directly into PLAY.
    - Otherwise go to IDLE.
    - Requests arriving during GAP set pending.
- `flush` overrides everything: next state IDLE, pending cleared, and any `req` in the same cycle is ignored.
- `mute` has no effect on state, counter or pending.
- Counter width is `$clog2(ONE_SEC)` bits. All durations fit that width.

## Timing
- Reset values: state IDLE, `pending`=0, counter=0, `sound_freq`=0, `enable_sound`=0, `active_id`=0, `busy`=0.
- All outputs are registered and computed from next-state values.
  - A `req` sampled at edge t into IDLE gives `enable_sound`=1 and the correct `sound_freq` after edge t.
- `enable_sound` is high for exactly DUR consecutive cycles per uninterrupted tone, then low for exactly GAP_CYCLES cycles.
- `enable_sound` = (next state == PLAY) && !`mute`. Mute therefore has one cycle of latency.
- `sound_freq` and `active_id` hold their last value through GAP and IDLE. `sound_freq` is 0 only after reset.
- A preemption changes `sound_freq` on the next edge with no gap cycle. `enable_sound` stays high throughout.
- Asserting `resetN` mid-tone clears all state asynchronously. No tone resumes after release.

## Structure
- Package `sound_pkg` holds:
  - enum `snd_id_t` {LOSE, WIN, GATE, HOP}
  - enum `snd_state_t` {IDLE, PLAY, GAP}
  - frequency localparams `LOSE_FREQ`=950, `WIN_FREQ`=500, `GATE_FREQ`=700, `HOP_FREQ`=300
  - function `dur_of(id, ONE_SEC)`
- Sub-module `sound_timer`: loadable down-counter with a `load`/`value` input and a `zero` flag. It is instantiated once and shared by PLAY and GAP.
- The priority encoder is inline combinational logic.

## Test plan
All scenarios use `ONE_SEC`=64, `GAP_CYCLES`=2.
- **Single tone:** `req`=4'b0100 pulse from IDLE → the next cycle `sound_freq`=700, `active_id`=2, `enable_sound` high for 16 cycles, then low for 2 cycles, then `busy`=0.
- **Simultaneous requests:** `req`=4'b1010 → WIN plays 64 cycles, 2-cycle gap, then HOP plays 4 cycles at 300 Hz.
- **Preemption:** HOP playing, LOSE pulse at cycle 2 → the next cycle has `sound_freq`=950 and `active_id`=0 with `enable_sound` never dropping. LOSE lasts 64 cycles and HOP is not resumed.
- **Restart and pending:** GATE playing, GATE pulse at cycle 10 → `enable_sound` high for 26 cycles total. A HOP pulse during that time plays after the gap.
- **Mute and flush:** `mute` held high through a WIN tone → `enable_sound` stays 0 but `busy` lasts 66 cycles. `flush` mid-tone with two pending → `enable_sound`=0 next cycle, IDLE, `pending`=0.
- **Reset:** `resetN` low mid-LOSE with WIN pending → all outputs 0 asynchronously. After release, no tone plays until a new `req`.
